// File: rtl/renode_axi_write_sink_if.sv
// AXI write-channel bundle (AW, W, B) between the Renode bridge manager and the write sink.
interface renode_axi_write_sink_if #(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int TransactionIdWidth = 8
);
    logic [TransactionIdWidth-1:0] awid;
    logic [AddressWidth-1:0]       awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awvalid;
    logic                          awready;
    logic [DataWidth-1:0]          wdata;
    logic [DataWidth/8-1:0]        wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;
    logic [TransactionIdWidth-1:0] bid;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/renode_axi_write_sink.sv
// AXI write sink: one burst at a time, expanded into per-beat byte-addressed memory writes.
// Define RENODE_AXI_WRITE_SINK_WRAP_EN to support WRAP bursts; otherwise WRAP answers SLVERR.
module renode_axi_write_sink #(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int TransactionIdWidth = 8
) (
    input  logic                      clk,
    input  logic                      areset,
    renode_axi_write_sink_if.slave    axi,
    output logic [AddressWidth-1:0]   mem_addr,
    output logic [DataWidth-1:0]      mem_wdata,
    output logic [DataWidth/8-1:0]    mem_wstrb,
    output logic                      mem_we,
    input  logic                      mem_ready
);
    localparam int         StrbWidth = DataWidth / 8;
    localparam logic [2:0] MaxSize   = 3'($clog2(StrbWidth));

    // state | meaning
    // IDLE  | waiting for an AW handshake
    // DATA  | draining len+1 W beats into the memory port
    // RESP  | presenting the B response
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                        state_q, state_d;
    logic                          live_q;
    logic [TransactionIdWidth-1:0] id_q;
    logic [AddressWidth-1:0]       addr_q, addr_next, bytes;
    logic [7:0]                    len_q, cnt_q;
    logic [2:0]                    size_q;
    logic [1:0]                    burst_q;
    logic                          aw_err_q, err_q, aw_err;
    logic                          aw_hs, beat, last_beat;

    assign aw_hs     = axi.awvalid && axi.awready;
    assign beat      = axi.wvalid && axi.wready;
    assign last_beat = (cnt_q == len_q);

`ifdef RENODE_AXI_WRITE_SINK_WRAP_EN
    assign aw_err = (axi.awsize > MaxSize) || (axi.awburst == 2'd3) ||
                    ((axi.awburst == 2'd2) && !(axi.awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
`else
    assign aw_err = (axi.awsize > MaxSize) || axi.awburst[1];
`endif

    assign bytes = AddressWidth'(1) << size_q;

`ifdef RENODE_AXI_WRITE_SINK_WRAP_EN
    logic [2:0]              wrap_shift;
    logic [AddressWidth-1:0] wrap_mask;

    // Legal WRAP lengths are 2/4/8/16 beats, so the top set bit of len gives log2(beats).
    always_comb begin
        wrap_shift = 3'd1;
        if (len_q[3])      wrap_shift = 3'd4;
        else if (len_q[2]) wrap_shift = 3'd3;
        else if (len_q[1]) wrap_shift = 3'd2;
    end

    assign wrap_mask = (bytes << wrap_shift) - AddressWidth'(1);
`endif

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            2'd1: addr_next = (addr_q & ~(bytes - AddressWidth'(1))) + bytes;
`ifdef RENODE_AXI_WRITE_SINK_WRAP_EN
            2'd2: addr_next = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
`endif
            default: addr_next = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                axi.awready = live_q;
                if (live_q && axi.awvalid) state_d = DATA;
            end
            DATA: begin
                axi.wready = mem_ready;
                mem_we     = axi.wvalid && !aw_err_q;
                if (axi.wvalid && mem_ready && last_beat) state_d = RESP;
            end
            RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // live_q holds awready low through the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (areset) begin
            live_q   <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            aw_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (aw_hs) begin
                id_q     <= axi.awid;
                addr_q   <= axi.awaddr;
                len_q    <= axi.awlen;
                size_q   <= axi.awsize;
                burst_q  <= axi.awburst;
                aw_err_q <= aw_err;
                err_q    <= aw_err;
                cnt_q    <= '0;
            end else if (beat) begin
                if (last_beat != axi.wlast) err_q <= 1'b1;
                if (!last_beat) begin
                    cnt_q  <= cnt_q + 8'd1;
                    addr_q <= addr_next;
                end
            end
        end
    end

    assign axi.bid   = id_q;
    assign axi.bresp = (state_q == RESP && err_q) ? 2'b10 : 2'b00;
    assign mem_addr  = addr_q;
    assign mem_wdata = axi.wdata;
    assign mem_wstrb = axi.wstrb;
endmodule

// File: tb/tb_renode_axi_write_sink.sv
// Self-checking bench for renode_axi_write_sink: directed vector table, hand sequences,
// and randomized bursts checked against an arithmetic model of the AXI address rules.
module tb_renode_axi_write_sink;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          areset;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_we;
    logic          mem_ready;

    always #5 clk = ~clk;

    renode_axi_write_sink_if #(.AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)) axi ();

    renode_axi_write_sink #(.AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)) dut (
        .clk       (clk),
        .areset    (areset),
        .axi       (axi.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_we    (mem_we),
        .mem_ready (mem_ready)
    );

    typedef struct {
        logic [7:0]        id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        int                bad_beat;
        logic [1:0]        exp_bresp;
        int                exp_writes;
        logic [3:0][31:0]  exp_a;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic aw_error(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
        int beats = int'(len) + 1;
        if (size > 3'd2) return 1'b1;
        if (burst == 2'd3) return 1'b1;
`ifdef RENODE_AXI_WRITE_SINK_WRAP_EN
        if (burst == 2'd2) return !(beats == 2 || beats == 4 || beats == 8 || beats == 16);
`else
        if (burst == 2'd2) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Closed-form address of beat n.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst, input int n);
        longint unsigned bytes = 64'd1 << size;
        longint unsigned total = bytes * (longint'(len) + 1);
        longint unsigned s     = 64'(start);
        longint unsigned nn    = 64'(n);
        case (burst)
            2'd1: begin
                if (n == 0) return start;
                return 32'((s / bytes) * bytes + nn * bytes);
            end
            2'd2: return 32'((s / total) * total + (s + nn * bytes) % total);
            default: return start;
        endcase
    endfunction

    // ready_mode: 0 = mem_ready always 1, 1 = random, 2 = toggles 1,0,1,0...
    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                             input int ready_mode, input bit rnd_valid, input bit rnd_bready,
                             output logic [1:0] got_bresp, output logic [7:0] got_bid, output int occ);
        int   guard;
        int   b;
        int   cyc;
        logic exp_awerr;
        wr_q.delete();
        occ       = 0;
        got_bresp = 2'bxx;
        got_bid   = 8'hxx;
        exp_awerr = aw_error(size, len, burst);
        @(negedge clk);
        axi.awvalid = 1'b1;
        axi.awid    = id;
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awsize  = size;
        axi.awburst = burst;
        #1;
        guard = 0;
        while (!axi.awready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("aw_accept", axi.awready, 1);
        if (!axi.awready) begin
            axi.awvalid = 1'b0;
            return;
        end
        @(posedge clk);
        b     = 0;
        cyc   = 0;
        guard = 0;
        while (b <= int'(len) && guard < 2000) begin
            @(negedge clk);
            axi.awvalid = 1'b0;
            axi.wvalid  = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (ready_mode)
                1:       mem_ready = 1'($urandom_range(0, 1));
                2:       mem_ready = (cyc % 2 == 0);
                default: mem_ready = 1'b1;
            endcase
            axi.wdata = $urandom;
            axi.wstrb = 4'($urandom);
            axi.wlast = (b == int'(len)) ^ (b == bad_beat);
            #1;
            check("wready_tracks_mem_ready", axi.wready, mem_ready);
            check("mem_we", mem_we, axi.wvalid && !exp_awerr);
            check("awready_busy", axi.awready, 0);
            if (axi.wvalid && axi.wready) begin
                check("wdata_pass", mem_wdata, axi.wdata);
                check("wstrb_pass", mem_wstrb, axi.wstrb);
                if (mem_we) wr_q.push_back(mem_addr);
                b++;
            end
            @(posedge clk);
            cyc++;
            guard++;
        end
        check("beats_done", b, int'(len) + 1);
        @(negedge clk);
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        mem_ready  = 1'b1;
        axi.bready = rnd_bready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        check("bvalid_latency", axi.bvalid, 1);
        guard = 0;
        while (!(axi.bvalid && axi.bready) && guard < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            axi.bready = rnd_bready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            guard++;
        end
        check("b_handshake", axi.bvalid && axi.bready, 1);
        got_bresp = axi.bresp;
        got_bid   = axi.bid;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        axi.bready = 1'b0;
        #1;
        check("bvalid_drops", axi.bvalid, 0);
        occ = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [1:0]  bresp;
        logic [7:0]  bid;
        int          occ;

        vecs[0] = '{8'h11, 32'h1000, 8'd3, 3'd2, 2'd1, -1, 2'd0, 4,
                    {32'h100C, 32'h1008, 32'h1004, 32'h1000}};
`ifdef RENODE_AXI_WRITE_SINK_WRAP_EN
        vecs[1] = '{8'h22, 32'h0018, 8'd3, 3'd2, 2'd2, -1, 2'd0, 4,
                    {32'h14, 32'h10, 32'h1C, 32'h18}};
`else
        vecs[1] = '{8'h22, 32'h0018, 8'd3, 3'd2, 2'd2, -1, 2'd2, 0, '0};
`endif
        vecs[2] = '{8'h33, 32'h0040, 8'd1, 3'd3, 2'd1, -1, 2'd2, 0, '0};
        vecs[3] = '{8'h44, 32'h2000, 8'd3, 3'd2, 2'd1, 1, 2'd2, 4,
                    {32'h200C, 32'h2008, 32'h2004, 32'h2000}};
        vecs[4] = '{8'h55, 32'h0080, 8'd0, 3'd2, 2'd3, -1, 2'd2, 0, '0};
        vecs[5] = '{8'h66, 32'h0100, 8'd2, 3'd2, 2'd2, -1, 2'd2, 0, '0};
        vecs[6] = '{8'h77, 32'h1003, 8'd2, 3'd2, 2'd1, -1, 2'd0, 3,
                    {32'h0, 32'h1008, 32'h1004, 32'h1003}};
        vecs[7] = '{8'h88, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'd1, -1, 2'd0, 2,
                    {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC}};
        vecs[8] = '{8'h99, 32'h0500, 8'd1, 3'd1, 2'd1, 1, 2'd2, 2,
                    {32'h0, 32'h0, 32'h502, 32'h500}};
        vecs[9] = '{8'hAA, 32'h0007, 8'd0, 3'd0, 2'd0, -1, 2'd0, 1,
                    {32'h0, 32'h0, 32'h0, 32'h7}};

        areset      = 1'b1;
        mem_ready   = 1'b1;
        axi.awvalid = 1'b0;
        axi.awid    = '0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awsize  = '0;
        axi.awburst = '0;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;

        // Reset values, then awready rises the first cycle after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_awready", axi.awready, 0);
        check("rst_wready", axi.wready, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_bid", axi.bid, 0);
        check("rst_bresp", axi.bresp, 0);
        check("rst_mem_addr", mem_addr, 0);
        areset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("awready_after_reset", axi.awready, 1);

        for (int i = 0; i < 10; i++) begin
            run_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                      vecs[i].bad_beat, 0, 1'b0, 1'b0, bresp, bid, occ);
            check($sformatf("vec%0d_bresp", i), bresp, vecs[i].exp_bresp);
            check($sformatf("vec%0d_bid", i), bid, vecs[i].id);
            check($sformatf("vec%0d_nwrites", i), wr_q.size(), vecs[i].exp_writes);
            check($sformatf("vec%0d_occupancy", i), occ, int'(vecs[i].len) + 2);
            for (int j = 0; j < vecs[i].exp_writes && j < wr_q.size(); j++)
                check($sformatf("vec%0d_addr%0d", i, j), wr_q[j], vecs[i].exp_a[j]);
        end

        // FIXED burst with mem_ready toggling 1,0,1,0,1.
        run_burst(8'h5A, 32'h200, 8'd2, 3'd2, 2'd0, -1, 2, 1'b0, 1'b0, bresp, bid, occ);
        check("fixed_bresp", bresp, 0);
        check("fixed_nwrites", wr_q.size(), 3);
        for (int j = 0; j < wr_q.size(); j++)
            check($sformatf("fixed_addr%0d", j), wr_q[j], 32'h200);

        // Reset during DATA after beat 1: burst discarded, no B response.
        @(negedge clk);
        axi.awvalid = 1'b1;
        axi.awid    = 8'h3C;
        axi.awaddr  = 32'h3000;
        axi.awlen   = 8'd3;
        axi.awsize  = 3'd2;
        axi.awburst = 2'd1;
        mem_ready   = 1'b1;
        #1;
        check("rst_seq_aw_ready", axi.awready, 1);
        @(posedge clk);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b1;
        axi.wlast   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_seq_beat1_addr", mem_addr, 32'h3004);
        @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midrst_awready", axi.awready, 0);
        check("midrst_wready", axi.wready, 0);
        check("midrst_bvalid", axi.bvalid, 0);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_bid", axi.bid, 0);
        check("midrst_bresp", axi.bresp, 0);
        check("midrst_mem_addr", mem_addr, 0);
        areset     = 1'b0;
        axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midrst_awready_rise", axi.awready, 1);
        check("midrst_no_bvalid", axi.bvalid, 0);
        axi.bready = 1'b0;
        run_burst(8'hC3, 32'h4000, 8'd1, 3'd2, 2'd1, -1, 0, 1'b0, 1'b0, bresp, bid, occ);
        check("post_rst_bresp", bresp, 0);
        check("post_rst_bid", bid, 8'hC3);
        check("post_rst_nwrites", wr_q.size(), 2);

        // Randomized bursts against the arithmetic model.
        for (int t = 0; t < 30; t++) begin
            logic [7:0]  r_id;
            logic [31:0] r_addr;
            logic [7:0]  r_len;
            logic [2:0]  r_size;
            logic [1:0]  r_burst;
            int          r_bad;
            logic        e_aw;
            int          e_n;
            r_id    = 8'($urandom);
            r_addr  = $urandom;
            r_len   = 8'($urandom_range(0, 15));
            r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r_burst = 2'($urandom_range(0, 3));
            r_bad   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
            run_burst(r_id, r_addr, r_len, r_size, r_burst, r_bad, 1, 1'b1, 1'b1, bresp, bid, occ);
            e_aw = aw_error(r_size, r_len, r_burst);
            e_n  = e_aw ? 0 : int'(r_len) + 1;
            check($sformatf("rnd%0d_bresp", t), bresp, (e_aw || r_bad >= 0) ? 2'd2 : 2'd0);
            check($sformatf("rnd%0d_bid", t), bid, r_id);
            check($sformatf("rnd%0d_nwrites", t), wr_q.size(), e_n);
            for (int j = 0; j < e_n && j < wr_q.size(); j++)
                check($sformatf("rnd%0d_addr%0d", t, j), wr_q[j],
                      beat_addr(r_addr, r_size, r_len, r_burst, j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/renode_axi_write_sink.md
# renode_axi_write_sink

- Subordinate-side consumer of the AXI write channels (AW, W, B) carried by the Renode AXI interface.
- Accepts one write burst at a time and expands it into per-beat byte-addressed writes on a simple memory port.
- Returns a single write response per burst.
- Sits directly downstream of the AXI manager driven by the Renode co-simulation bridge; feeds a memory model or register file.

## Interface

Parameters:
- AddressWidth, 32, AXI/memory byte-address width
- DataWidth, 32, data width; multiple of 8
- TransactionIdWidth, 8, AWID/BID width

Ports:
- clk  in  1  single clock; all logic on posedge
- areset  in  1  reset, synchronous, active-high
- awid  in  TransactionIdWidth  write transaction ID
- awaddr  in  AddressWidth  burst start byte address
- awlen  in  8  beats minus one
- awsize  in  3  log2 bytes per beat
- awburst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DataWidth  write data
- wstrb  in  DataWidth/8  byte strobes
- wlast  in  1  last beat marker
- wvalid / wready  in / out  1  W handshake
- bid  out  TransactionIdWidth  echoed awid
- bresp  out  2  0=OKAY, 2=SLVERR
- bvalid / bready  out / in  1  B handshake
- mem_addr  out  AddressWidth  current beat byte address
- mem_wdata  out  DataWidth  wdata passthrough
- mem_wstrb  out  DataWidth/8  wstrb passthrough
- mem_we  out  1  write strobe; the beat is committed when mem_we && mem_ready
- mem_ready  in  1  memory can accept a write this cycle

## Operation

FSM states: IDLE, DATA, RESP.

- **IDLE**
  - awready=1.
  - On awvalid: latch id, addr, len, size, burst; compute the error flag; go to DATA. Beat counter is cleared.
- **DATA**
  - wready = mem_ready.
  - mem_we = wvalid && !err (combinational).
  - A beat completes on wvalid && wready.
  - On the beat where counter==len, go to RESP; otherwise increment the counter and advance the address.
- **RESP**
  - bvalid=1; bid and bresp held stable.
  - On bready, return to IDLE.

Error flag (SLVERR) is set at AW latch if any of:
- awsize > log2(DataWidth/8)
- awburst==3
- WRAP with len+1 not in {2,4,8,16}

Error flag is also set during DATA if:
- wlast=1 on a beat before the final beat, or
- wlast=0 on the final beat.

Errored bursts still drain exactly len+1 beats. When the error flag was set at AW latch, mem_we stays 0 for the whole burst.

Address advance (bytes = 1<<size):
- FIXED: unchanged.
- INCR: next = (addr & ~(bytes-1)) + bytes, width-truncated.
- WRAP: total = bytes*(len+1); next = (addr & ~(total-1)) | ((addr+bytes) & (total-1)).

## Timing

- Reset values:
  - awready=0, wready=0, bvalid=0, mem_we=0
  - bid=0, bresp=0, mem_addr=0
  - state=IDLE
- awready rises the first cycle after areset deasserts.
- Single outstanding burst; awready=0 outside IDLE.
- Latency:
  - AW handshake at cycle N → first W beat acceptable at N+1.
  - Last W beat at cycle M → bvalid=1 at M+1.
  - Minimum burst occupancy is len+3 cycles.
- mem_ready low stalls W (wready=0) with no state change.
- wvalid may drop mid-burst; the address and counter hold.
- areset asserted in any state → IDLE next cycle. An in-flight burst is discarded with no B response.

## Configuration

- RENODE_AXI_WRITE_SINK_WRAP_EN
  - Defined: WRAP bursts are supported per the rules above.
  - Undefined: WRAP is treated like reserved. The burst drains, there are no memory writes, and bresp=SLVERR; the WRAP address logic is not synthesized.

## Test plan

- INCR, awaddr=0x1000, len=3, size=2, mem_ready=1 → mem_addr 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; bresp=0; bvalid one cycle after the last beat.
- WRAP (macro on), awaddr=0x0018, len=3, size=2 → addresses 0x18, 0x1C, 0x10, 0x14; bresp=0. With the macro off: no mem_we, bresp=2.
- FIXED, awaddr=0x200, len=2, mem_ready toggling 1,0,1,0,1 → three writes, all at 0x200; wready tracks mem_ready.
- awsize=3 with DataWidth=32 and len=1 → two W beats accepted, mem_we never high, bresp=2, bid=awid.
- INCR, len=3, wlast asserted on beat 1 → all four beats still written; bresp=2.
- areset pulsed during DATA after beat 1 → next cycle all outputs at reset values, no bvalid; a new AW is accepted afterwards.
